// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// op encodings, default latencies and the controller state type.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdOp_e;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;
  localparam int CNT_W               = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdState_e;

endpackage

// File: rtl/md_if.sv
// EX-stage mult/div command bus plus the HI/LO, busy and hazard outputs.
// The pipeline side is the master; the sequencer is the slave.
interface md_if;
  import md_pkg::*;

  logic        start;
  mdOp_e       op;
  logic        mthi;
  logic        mtlo;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        md_use_d;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_stall;
  logic        err_overlap;

  modport master (
    output start, op, mthi, mtlo, srcA, srcB, md_use_d,
    input  busy, hi, lo, md_stall, err_overlap
  );

  modport slave (
    input  start, op, mthi, mtlo, srcA, srcB, md_use_d,
    output busy, hi, lo, md_stall, err_overlap
  );

endinterface

// File: rtl/md_arith.sv
// Combinational result generator for mult/multu/div/divu.
// Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
module md_arith
  import md_pkg::*;
(
  input  mdOp_e       op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic [31:0] resHi,
  output logic [31:0] resLo,
  output logic        divZero
);

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic        signedDiv;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] divisor;
  logic [31:0] quoU;
  logic [31:0] remU;
  logic        quoNeg;
  logic        remNeg;

  assign prodS = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
  assign prodU = {32'd0, srcA} * {32'd0, srcB};

  assign divZero   = (srcB == 32'd0);
  assign signedDiv = (op == MD_DIV);
  assign magA      = (signedDiv && srcA[31]) ? -srcA : srcA;
  assign magB      = (signedDiv && srcB[31]) ? -srcB : srcB;
  // A zero divisor is replaced so the divider never produces X; the
  // controller discards this result anyway.
  assign divisor   = divZero ? 32'd1 : magB;
  assign quoU      = magA / divisor;
  assign remU      = magA % divisor;
  assign quoNeg    = signedDiv & (srcA[31] ^ srcB[31]);
  assign remNeg    = signedDiv & srcA[31];

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    resHi = 32'd0;
    resLo = 32'd0;
    unique case (op)
      MD_MULT:  {resHi, resLo} = prodS;
      MD_MULTU: {resHi, resLo} = prodU;
      default: begin
        resHi = remNeg ? -remU : remU;
        resLo = quoNeg ? -quoU : quoU;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: captures a result, holds busy for a fixed
// latency, then commits to HI/LO. Also raises the decode-stage HI/LO stall.
module muldiv_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam cnt_t CNT_ONE = cnt_t'(1);

  mdState_e    state;
  mdState_e    nextState;
  cnt_t        cnt;
  cnt_t        cntNext;

  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic [31:0] pendHi;
  logic [31:0] pendLo;
  logic        pendDz;
  logic        errReg;

  logic [31:0] resHi;
  logic [31:0] resLo;
  logic        divZero;

  logic        loadPend;
  logic        commit;
  logic        wrHi;
  logic        wrLo;
  logic        overlap;

  md_arith uArith (
    .op      (bus.op),
    .srcA    (bus.srcA),
    .srcB    (bus.srcB),
    .resHi   (resHi),
    .resLo   (resLo),
    .divZero (divZero)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    loadPend  = 1'b0;
    commit    = 1'b0;
    wrHi      = 1'b0;
    wrLo      = 1'b0;
    overlap   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          // start takes priority; a coincident mthi/mtlo is dropped
          nextState = RUN;
          cntNext   = bus.op[1] ? cnt_t'(DIV_CYCLES) : cnt_t'(MULT_CYCLES);
          loadPend  = 1'b1;
        end else begin
          wrHi = bus.mthi;
          wrLo = bus.mtlo;
        end
      end
      RUN: begin
        overlap = bus.start | bus.mthi | bus.mtlo;
        cntNext = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          nextState = IDLE;
          commit    = ~pendDz;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hiReg  <= 32'd0;
      loReg  <= 32'd0;
      pendHi <= 32'd0;
      pendLo <= 32'd0;
      pendDz <= 1'b0;
      errReg <= 1'b0;
    end else begin
      errReg <= overlap;
      if (loadPend) begin
        pendHi <= resHi;
        pendLo <= resLo;
        pendDz <= divZero & bus.op[1];
      end
      if (commit) begin
        hiReg <= pendHi;
        loReg <= pendLo;
      end
      if (wrHi) hiReg <= bus.srcA;
      if (wrLo) loReg <= bus.srcA;
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.hi          = hiReg;
  assign bus.lo          = loReg;
  assign bus.err_overlap = errReg;
  // The EX-stage start itself must stall a following HI/LO user.
  assign bus.md_stall    = bus.md_use_d & (bus.busy | bus.start);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected commits from a
// plain-arithmetic model; a negedge monitor checks them when busy falls.
module tb_muldiv_ctrl;
  import md_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_if bus ();

  muldiv_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mHi;
  logic [31:0] mLo;
  bit          allowOverlap;
  int          vectors;
  int          miscompares;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model from the architectural rules, using native int arithmetic.
  function automatic void model(input mdOp_e op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    int              ia;
    int              ib;
    longint          ps;
    longint unsigned pu;
    ia = a;
    ib = b;
    case (op)
      MD_MULT: begin
        ps = longint'(ia) * longint'(ib);
        h  = ps[63:32];
        l  = ps[31:0];
      end
      MD_MULTU: begin
        pu = longint'(a) * longint'(b);
        h  = pu[63:32];
        l  = pu[31:0];
      end
      MD_DIV: begin
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = a;
            h = 32'd0;
          end else begin
            l = ia / ib;
            h = ia % ib;
          end
        end
      end
      default: begin
        if (b != 0) begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  task automatic issue(input mdOp_e op, input logic [31:0] a, input logic [31:0] b,
                       input bit withMt = 1'b0);
    exp_t e;
    model(op, a, b, mHi, mLo);
    e.lat = op[1] ? DIV_N : MULT_N;
    e.hi  = mHi;
    e.lo  = mLo;
    sbq.push_back(e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.srcA  = a;
    bus.srcB  = b;
    bus.mthi  = withMt;
    bus.mtlo  = withMt;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (bus.busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle", bus.busy, 0);
  endtask

  task automatic mtWrite(input bit h, input bit l, input logic [31:0] v);
    bus.mthi = h;
    bus.mtlo = l;
    bus.srcA = v;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    if (h) mHi = v;
    if (l) mLo = v;
    check("mt_hi", bus.hi, mHi);
    check("mt_lo", bus.lo, mLo);
    check("mt_busy", bus.busy, 0);
  endtask

  // Monitor: measures each busy window and checks the commit it ends with.
  initial begin : monitor
    int   busyCycles = 0;
    logic prevBusy   = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busyCycles = 0;
        prevBusy   = 1'b0;
      end else begin
        if (bus.busy) begin
          busyCycles++;
        end else if (prevBusy) begin
          if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_commit: busy fell with no operation outstanding");
          end else begin
            e = sbq.pop_front();
            check("latency", busyCycles, e.lat);
            check("commit_hi", bus.hi, e.hi);
            check("commit_lo", bus.lo, e.lo);
          end
          busyCycles = 0;
        end
        if (bus.err_overlap && !allowOverlap) check("err_overlap", bus.err_overlap, 0);
        prevBusy = bus.busy;
      end
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int   errCount;
    bit   stallOk;
    int   kind;
    mdOp_e rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vectors      = 0;
    miscompares  = 0;
    allowOverlap = 1'b0;
    mHi = 32'd0;
    mLo = 32'd0;
    bus.start = 1'b0;  bus.op = MD_MULT;  bus.mthi = 1'b0;  bus.mtlo = 1'b0;
    bus.srcA = 32'd0;  bus.srcB = 32'd0;  bus.md_use_d = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_busy", bus.busy, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_err", bus.err_overlap, 0);
    check("rst_stall", bus.md_stall, 0);

    // Signed multiply -2 * 3
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    waitIdle();
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);

    // Signed divide -7 / 2
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    waitIdle();
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    // Divide by zero leaves HI/LO untouched
    mtWrite(1'b1, 1'b0, 32'h11);
    mtWrite(1'b0, 1'b1, 32'h22);
    issue(MD_DIVU, 32'h1234, 32'd0);
    waitIdle();
    check("dz_hi", bus.hi, 32'h11);
    check("dz_lo", bus.lo, 32'h22);

    // Overlap and stall
    allowOverlap = 1'b1;
    errCount     = 0;
    stallOk      = 1'b1;
    bus.md_use_d = 1'b1;
    begin
      exp_t e;
      model(MD_MULTU, 32'hDEAD_BEEF, 32'h0000_1234, mHi, mLo);
      e.lat = MULT_N;  e.hi = mHi;  e.lo = mLo;
      sbq.push_back(e);
    end
    bus.start = 1'b1;  bus.op = MD_MULTU;
    bus.srcA = 32'hDEAD_BEEF;  bus.srcB = 32'h0000_1234;
    #1 stallOk &= bus.md_stall;
    @(posedge clk); #1 bus.start = 1'b0;
    stallOk &= bus.md_stall;
    errCount += int'(bus.err_overlap);
    @(posedge clk); #1;
    bus.start = 1'b1;  bus.op = MD_DIV;
    bus.srcA = 32'h7;  bus.srcB = 32'h3;
    #1 stallOk &= bus.md_stall;
    errCount += int'(bus.err_overlap);
    @(posedge clk); #1 bus.start = 1'b0;
    for (int n = 0; n < 20 && bus.busy; n++) begin
      stallOk &= bus.md_stall;
      errCount += int'(bus.err_overlap);
      @(posedge clk); #1;
    end
    errCount += int'(bus.err_overlap);
    check("ovl_busy_end", bus.busy, 0);
    check("ovl_err_count", errCount, 1);
    check("ovl_stall_window", stallOk, 1);
    check("ovl_stall_idle", bus.md_stall, 0);
    check("ovl_hi", bus.hi, mHi);
    check("ovl_lo", bus.lo, mLo);
    bus.md_use_d = 1'b0;
    @(posedge clk); #1;
    allowOverlap = 1'b0;

    // Reset during busy cycle 4 aborts without commit
    issue(MD_DIV, 32'h0000_1000, 32'h0000_0007);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    sbq.delete();
    @(posedge clk); #1 reset = 1'b0;
    mHi = 32'd0;
    mLo = 32'd0;
    check("abort_busy", bus.busy, 0);
    check("abort_hi", bus.hi, 0);
    check("abort_lo", bus.lo, 0);
    repeat (12) begin @(posedge clk); #1; end
    check("abort_late_hi", bus.hi, 0);
    check("abort_late_lo", bus.lo, 0);
    check("abort_late_busy", bus.busy, 0);

    // Unsigned multiply then a back-to-back mult
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitIdle();
    check("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo, 32'h0000_0001);
    issue(MD_MULT, 32'h8000_0000, 32'h0000_0002);
    check("b2b_busy", bus.busy, 1);
    waitIdle();

    // INT_MIN / -1, mthi+mtlo together, start beating a coincident mt write
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle();
    check("ovf_lo", bus.lo, 32'h8000_0000);
    check("ovf_hi", bus.hi, 32'h0);
    mtWrite(1'b1, 1'b1, 32'hA5A5_5A5A);
    issue(MD_DIVU, 32'd100, 32'd7, 1'b1);
    waitIdle();

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      ra   = $urandom;
      rb   = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      if (kind < 3) begin
        mtWrite(kind != 1, kind != 0, ra);
      end else begin
        rop = mdOp_e'(2'($urandom_range(0, 3)));
        issue(rop, ra, rb, kind == 9);
        if (kind > 6) waitIdle();
        else begin
          while (bus.busy) begin @(posedge clk); #1; end
        end
      end
    end
    repeat (2) @(posedge clk);
    #1 check("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
